// File: rtl/mgmt_i2c_event_xfer.sv
// Operational-frame side of the I2C/SMBus tunnel.
// TX: buffers nonzero relay event codes in per-channel FIFOs and hands one
// event per channel to each outgoing operational frame.
// RX: forwards nonzero per-channel event codes of CRC-valid received frames
// to the relays as one-cycle strobes; counts CRC-failed frames.
module mgmt_i2c_event_xfer #(
  parameter int NUM_OF_SMBUS_DEV = 6,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        link_operational,
  input  logic [5:0]  soft_i2c_channel_rst,
  input  logic [23:0] relay_event_i,
  input  logic [5:0]  relay_event_vld_i,
  input  logic        frame_tx_req,
  output logic [23:0] frame_i2c_o,
  input  logic        frame_rx_vld,
  input  logic        frame_rx_crc_ok,
  input  logic [23:0] frame_i2c_i,
  output logic [23:0] relay_event_o,
  output logic [5:0]  relay_event_vld_o,
  output logic [5:0]  tx_fifo_overflow,
  output logic [15:0] rx_drop_cnt
);

  // Pointer index width; one extra MSB separates full from empty.
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  logic        w_rx_acc;
  logic        w_rx_bad;
  logic [15:0] r_rx_drop_cnt;

  // Received frames are only meaningful while the link is operational.
  assign w_rx_acc = link_operational & frame_rx_vld & frame_rx_crc_ok;
  assign w_rx_bad = link_operational & frame_rx_vld & ~frame_rx_crc_ok;

  // Saturating count of frames discarded for CRC error; kept across link drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_drop_cnt <= 16'h0000;
    end else if (w_rx_bad && (r_rx_drop_cnt != 16'hFFFF)) begin
      r_rx_drop_cnt <= r_rx_drop_cnt + 16'd1;
    end
  end

  assign rx_drop_cnt = r_rx_drop_cnt;

  genvar ch;
  generate
    for (ch = 0; ch < 6; ch++) begin : g_ch
      if (ch < NUM_OF_SMBUS_DEV) begin : g_act
        logic [3:0]  r_mem [FIFO_DEPTH];
        logic [AW:0] r_wptr;
        logic [AW:0] r_rptr;
        logic [3:0]  r_tx_evt;
        logic [3:0]  r_rx_evt;
        logic        r_rx_vld;
        logic        r_ovf;
        logic [3:0]  w_code;
        logic [3:0]  w_rx_code;
        logic        w_srst;
        logic        w_empty;
        logic        w_full;
        logic        w_push_req;
        logic        w_pop;
        logic        w_push;

        assign w_code    = relay_event_i[4*ch +: 4];
        assign w_rx_code = frame_i2c_i[4*ch +: 4];
        assign w_srst    = soft_i2c_channel_rst[ch];
        assign w_empty   = (r_wptr == r_rptr);
        assign w_full    = (r_wptr[AW] != r_rptr[AW]) &&
                           (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

        // IDLE codes are never queued; channel reset and link-down win over traffic.
        assign w_push_req = link_operational & ~w_srst & relay_event_vld_i[ch] &
                            (w_code != 4'h0);
        // Emptiness is judged before this cycle's push, so a same-cycle push
        // into an empty FIFO waits for the next frame.
        assign w_pop      = link_operational & ~w_srst & frame_tx_req & ~w_empty;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        assign w_push     = w_push_req & (~w_full | w_pop);

        // Event storage; contents are don't-care while the pointers say empty.
        always_ff @(posedge clk) begin
          if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= w_code;
          end
        end

        // FIFO pointers; flush by collapsing both to zero.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
          end else if (!link_operational || w_srst) begin
            r_wptr <= '0;
            r_rptr <= '0;
          end else begin
            if (w_push) begin
              r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
              r_rptr <= r_rptr + PTR_ONE;
            end
          end
        end

        // Outgoing frame field: refreshed on each frame request, held otherwise.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            r_tx_evt <= 4'h0;
          end else if (!link_operational || w_srst) begin
            r_tx_evt <= 4'h0;
          end else if (frame_tx_req) begin
            r_tx_evt <= w_pop ? r_mem[r_rptr[AW-1:0]] : 4'h0;
          end
        end

        // Sticky overflow: set when a push is dropped, cleared only by channel reset.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            r_ovf <= 1'b0;
          end else if (w_srst) begin
            r_ovf <= 1'b0;
          end else if (w_push_req && w_full && !w_pop) begin
            r_ovf <= 1'b1;
          end
        end

        // RX delivery: code held until the next accepted event, strobe for one cycle.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            r_rx_evt <= 4'h0;
            r_rx_vld <= 1'b0;
          end else if (w_srst) begin
            r_rx_evt <= 4'h0;
            r_rx_vld <= 1'b0;
          end else if (w_rx_acc && (w_rx_code != 4'h0)) begin
            r_rx_evt <= w_rx_code;
            r_rx_vld <= 1'b1;
          end else begin
            r_rx_vld <= 1'b0;
          end
        end

        assign frame_i2c_o[4*ch +: 4]   = r_tx_evt;
        assign relay_event_o[4*ch +: 4] = r_rx_evt;
        assign relay_event_vld_o[ch]    = r_rx_vld;
        assign tx_fifo_overflow[ch]     = r_ovf;
      end else begin : g_idle
        // Unpopulated channel: no storage, outputs permanently idle.
        assign frame_i2c_o[4*ch +: 4]   = 4'h0;
        assign relay_event_o[4*ch +: 4] = 4'h0;
        assign relay_event_vld_o[ch]    = 1'b0;
        assign tx_fifo_overflow[ch]     = 1'b0;
      end
    end
  endgenerate

endmodule

// File: tb/tb_mgmt_i2c_event_xfer.sv
// Directed bench for mgmt_i2c_event_xfer with a per-channel TX scoreboard.
module tb_mgmt_i2c_event_xfer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        link_operational;
  logic [5:0]  soft_i2c_channel_rst;
  logic [23:0] relay_event_i;
  logic [5:0]  relay_event_vld_i;
  logic        frame_tx_req;
  logic [23:0] frame_i2c_o;
  logic        frame_rx_vld;
  logic        frame_rx_crc_ok;
  logic [23:0] frame_i2c_i;
  logic [23:0] relay_event_o;
  logic [5:0]  relay_event_vld_o;
  logic [5:0]  tx_fifo_overflow;
  logic [15:0] rx_drop_cnt;

  mgmt_i2c_event_xfer #(.NUM_OF_SMBUS_DEV(6), .FIFO_DEPTH(4)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .link_operational     (link_operational),
    .soft_i2c_channel_rst (soft_i2c_channel_rst),
    .relay_event_i        (relay_event_i),
    .relay_event_vld_i    (relay_event_vld_i),
    .frame_tx_req         (frame_tx_req),
    .frame_i2c_o          (frame_i2c_o),
    .frame_rx_vld         (frame_rx_vld),
    .frame_rx_crc_ok      (frame_rx_crc_ok),
    .frame_i2c_i          (frame_i2c_i),
    .relay_event_o        (relay_event_o),
    .relay_event_vld_o    (relay_event_vld_o),
    .tx_fifo_overflow     (tx_fifo_overflow),
    .rx_drop_cnt          (rx_drop_cnt)
  );

  always #5 clk = ~clk;

  localparam int DEPTH = 4;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [3:0] sb_q [6][$];
  logic [5:0] exp_ovf = 6'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    soft_i2c_channel_rst = 6'b0;
    relay_event_i        = 24'h0;
    relay_event_vld_i    = 6'b0;
    frame_tx_req         = 1'b0;
    frame_rx_vld         = 1'b0;
    frame_rx_crc_ok      = 1'b0;
    frame_i2c_i          = 24'h0;
  endtask

  task automatic flush_model();
    for (int c = 0; c < 6; c++) sb_q[c].delete();
  endtask

  // One clock of TX traffic with link up: model pops the head on a frame
  // request first, then queues pushes; a push into a full queue overflows.
  task automatic cyc(input logic [5:0] pv, input logic [23:0] pc, input logic treq,
                     input string tag);
    logic [3:0] exp_tx [6];
    logic [3:0] code;
    @(negedge clk);
    relay_event_vld_i = pv;
    relay_event_i     = pc;
    frame_tx_req      = treq;
    for (int c = 0; c < 6; c++) begin
      exp_tx[c] = 4'h0;
      if (treq && sb_q[c].size() > 0) exp_tx[c] = sb_q[c].pop_front();
    end
    for (int c = 0; c < 6; c++) begin
      code = pc[4*c +: 4];
      if (pv[c] && code != 4'h0) begin
        if (sb_q[c].size() < DEPTH) sb_q[c].push_back(code);
        else exp_ovf[c] = 1'b1;
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    if (treq) begin
      for (int c = 0; c < 6; c++)
        check($sformatf("%s_frame_ch%0d", tag, c), {28'h0, frame_i2c_o[4*c +: 4]}, {28'h0, exp_tx[c]});
    end
    check({tag, "_ovf"}, {26'h0, tx_fifo_overflow}, {26'h0, exp_ovf});
  endtask

  task automatic rx_frame(input logic crc, input logic [23:0] data, input logic [5:0] srst);
    @(negedge clk);
    frame_rx_vld         = 1'b1;
    frame_rx_crc_ok      = crc;
    frame_i2c_i          = data;
    soft_i2c_channel_rst = srst;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset_n          = 1'b0;
    link_operational = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_frame",    {8'h0, frame_i2c_o},        32'h0);
    check("rst_relay",    {8'h0, relay_event_o},      32'h0);
    check("rst_relayvld", {26'h0, relay_event_vld_o}, 32'h0);
    check("rst_ovf",      {26'h0, tx_fifo_overflow},  32'h0);
    check("rst_drop",     {16'h0, rx_drop_cnt},       32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // FIFO order on ch0, then empty read.
    cyc(6'b000001, 24'h000003, 1'b0, "t1_push3");
    cyc(6'b000001, 24'h000005, 1'b0, "t1_push5");
    cyc(6'b000001, 24'h000007, 1'b0, "t1_push7");
    cyc(6'b000000, 24'h0,      1'b1, "t1_req1");
    cyc(6'b000000, 24'h0,      1'b1, "t1_req2");
    cyc(6'b000000, 24'h0,      1'b1, "t1_req3");
    cyc(6'b000000, 24'h0,      1'b1, "t1_req4");

    // IDLE code is ignored; push on empty FIFO with same-cycle request waits a frame.
    cyc(6'b010000, 24'h000000, 1'b0, "t2_idle");
    cyc(6'b010000, 24'h060000, 1'b1, "t2_samecyc");
    cyc(6'b000000, 24'h0,      1'b1, "t2_next");

    // Full FIFO on ch3 plus simultaneous push and request.
    for (int i = 1; i <= 4; i++) cyc(6'b001000, 24'(i) << 12, 1'b0, "t3_fill");
    cyc(6'b001000, 24'h00A000, 1'b1, "t3_pushpop");
    for (int i = 0; i < 5; i++) cyc(6'b000000, 24'h0, 1'b1, "t3_drain");

    // Overflow on ch2: five pushes, four survive.
    for (int i = 0; i < 5; i++) cyc(6'b000100, 24'(8 + i) << 8, 1'b0, "t4_fill");
    for (int i = 0; i < 4; i++) cyc(6'b000000, 24'h0, 1'b1, "t4_drain");
    cyc(6'b000100, 24'h000D00, 1'b0, "t4_pushD");
    cyc(6'b000100, 24'h000E00, 1'b0, "t4_pushE");
    cyc(6'b100000, 24'hF00000, 1'b0, "t4_pushF");
    cyc(6'b000000, 24'h0,      1'b1, "t4_req");

    // Link drop while ch1 holds two events.
    cyc(6'b000010, 24'h0000C0, 1'b0, "t5_pushC");
    cyc(6'b000010, 24'h0000D0, 1'b0, "t5_pushD");
    @(negedge clk);
    link_operational  = 1'b0;
    relay_event_vld_i = 6'b000010;
    relay_event_i     = 24'h000090;
    frame_rx_vld      = 1'b1;
    frame_rx_crc_ok   = 1'b0;
    flush_model();
    @(posedge clk); #1;
    idle_inputs();
    check("t5_frame_zero", {8'h0, frame_i2c_o},       32'h0);
    check("t5_ovf_kept",   {26'h0, tx_fifo_overflow}, {26'h0, exp_ovf});
    check("t5_drop_kept",  {16'h0, rx_drop_cnt},      32'h0);
    @(negedge clk);
    link_operational = 1'b1;
    cyc(6'b000000, 24'h0, 1'b1, "t5_after");

    // Channel reset on ch2 clears its flag, output field and queue.
    cyc(6'b000100, 24'h000700, 1'b0, "t6_push7");
    cyc(6'b000100, 24'h000600, 1'b0, "t6_push6");
    cyc(6'b000000, 24'h0,      1'b1, "t6_req");
    @(negedge clk);
    soft_i2c_channel_rst = 6'b000100;
    sb_q[2].delete();
    exp_ovf[2] = 1'b0;
    @(posedge clk); #1;
    idle_inputs();
    check("t6_frame2_zero", {28'h0, frame_i2c_o[11:8]}, 32'h0);
    check("t6_ovf_clr",     {26'h0, tx_fifo_overflow},  {26'h0, exp_ovf});
    cyc(6'b000000, 24'h0, 1'b1, "t6_after");

    // RX good frame: ch0=4, ch2=9.
    rx_frame(1'b1, 24'h000904, 6'b0);
    check("t7_vld",    {26'h0, relay_event_vld_o}, 32'h05);
    check("t7_evt0",   {28'h0, relay_event_o[3:0]},  32'h4);
    check("t7_evt2",   {28'h0, relay_event_o[11:8]}, 32'h9);
    @(posedge clk); #1;
    check("t7_vld_end", {26'h0, relay_event_vld_o}, 32'h0);
    check("t7_hold",    {8'h0, relay_event_o},      32'h000904);
    // Channel reset on ch0 during an accepted frame suppresses its strobe.
    rx_frame(1'b1, 24'h000301, 6'b000001);
    check("t7_srst_vld",  {26'h0, relay_event_vld_o}, 32'h04);
    check("t7_srst_evt",  {8'h0, relay_event_o},      32'h000300);

    // CRC-failed frames.
    for (int i = 0; i < 3; i++) begin
      rx_frame(1'b0, 24'h555555, 6'b0);
      check("t8_bad_vld", {26'h0, relay_event_vld_o}, 32'h0);
    end
    check("t8_drop3", {16'h0, rx_drop_cnt}, 32'd3);
    check("t8_relay_kept", {8'h0, relay_event_o}, 32'h000300);
    @(negedge clk);
    frame_rx_vld    = 1'b1;
    frame_rx_crc_ok = 1'b0;
    repeat (65532) @(negedge clk);
    idle_inputs();
    #1;
    check("t8_drop_max", {16'h0, rx_drop_cnt}, 32'h0000FFFF);
    rx_frame(1'b0, 24'h0, 6'b0);
    check("t8_drop_sat", {16'h0, rx_drop_cnt}, 32'h0000FFFF);

    // Asynchronous reset mid-traffic.
    cyc(6'b000001, 24'h000005, 1'b0, "t9_push");
    cyc(6'b000001, 24'h000006, 1'b1, "t9_req");
    rx_frame(1'b1, 24'h000002, 6'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("t9_frame", {8'h0, frame_i2c_o},        32'h0);
    check("t9_relay", {8'h0, relay_event_o},      32'h0);
    check("t9_vld",   {26'h0, relay_event_vld_o}, 32'h0);
    check("t9_drop",  {16'h0, rx_drop_cnt},       32'h0);
    flush_model();
    exp_ovf = 6'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cyc(6'b000000, 24'h0, 1'b1, "t9_after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mgmt_i2c_event_xfer.md
Name: mgmt_i2c_event_xfer

Overview:
- Operational-frame side of the I2C/SMBus tunnel; the counterpart to the SMBus relay management block.
- TX path: collects per-channel I2C event codes produced by the relays and buffers them in per-channel FIFOs. Places one event per channel into each outgoing operational frame.
- RX path: extracts per-channel event codes from each received, CRC-valid operational frame and presents them to the relays as one-cycle-qualified events.

Parameters:
- NUM_OF_SMBUS_DEV, 6: number of active channels (1..6); channels at or above this index are tied idle.
- FIFO_DEPTH, 4: TX event FIFO depth per channel; power of 2, range 2..16.

Ports:
- clk  input  1  block clock, 60 MHz.
- reset_n  input  1  asynchronous active-low reset.
- link_operational  input  1  high when both local and remote link state are operational.
- soft_i2c_channel_rst  input  6  per-channel synchronous flush.
- relay_event_i  input  6x4  event code from each relay.
- relay_event_vld_i  input  6  one-cycle strobe qualifying relay_event_i[ch].
- frame_tx_req  input  1  one-cycle strobe: the frame builder is about to latch TX event fields.
- frame_i2c_o  output  6x4  per-channel event field for the outgoing frame.
- frame_rx_vld  input  1  one-cycle strobe: a received operational frame is decoded.
- frame_rx_crc_ok  input  1  CRC status of that frame, valid with frame_rx_vld.
- frame_i2c_i  input  6x4  per-channel event field of the received frame.
- relay_event_o  output  6x4  event code to each relay.
- relay_event_vld_o  output  6  one-cycle strobe qualifying relay_event_o[ch].
- tx_fifo_overflow  output  6  sticky per-channel overflow flag.
- rx_drop_cnt  output  16  count of received frames discarded for CRC error; saturating.

Behaviour:
- Event code 4'h0 is IDLE.
  - It is never pushed: a valid strobe carrying 0 is ignored.
  - It is never forwarded on RX: the relay sees no strobe.
- Reset values:
  - frame_i2c_o = 0, relay_event_o = 0, relay_event_vld_o = 0.
  - tx_fifo_overflow = 0, rx_drop_cnt = 0.
  - All FIFOs empty.
- TX push: when relay_event_vld_i[ch] is high and the code is nonzero, the code is written at the clock edge.
- TX pop:
  - On frame_tx_req, each nonempty channel pops its head into frame_i2c_o[ch]; each empty channel drives 0.
  - frame_i2c_o updates in the cycle after frame_tx_req and holds until the next frame_tx_req.
- Same-cycle push and frame_tx_req on an empty FIFO: the pushed event is not emitted this frame; it goes out on the following frame_tx_req. Order is strictly FIFO.
- Full FIFO:
  - Push without a same-cycle pop: the event is dropped and tx_fifo_overflow[ch] is set.
  - Push with a same-cycle pop: both occur, occupancy is unchanged, no overflow.
- Pointers: log2(FIFO_DEPTH)-bit pointers wrap modulo depth; an extra count bit distinguishes full from empty.
- RX accept: on frame_rx_vld && frame_rx_crc_ok, for each active channel with a nonzero code:
  - relay_event_o[ch] takes the code in the next cycle;
  - relay_event_vld_o[ch] pulses high for exactly 1 cycle;
  - relay_event_o holds its value until the next accepted event.
- RX discard: on frame_rx_vld && !frame_rx_crc_ok, no relay strobe fires and rx_drop_cnt increments, saturating at 16'hFFFF.
- Link gating: while link_operational == 0:
  - all FIFOs are flushed and pushes are ignored;
  - frame_i2c_o is forced to 0 in the next cycle;
  - frame_rx_vld is ignored (rx_drop_cnt is not incremented);
  - tx_fifo_overflow and rx_drop_cnt are retained.
- soft_i2c_channel_rst[ch] (synchronous, has priority over push/pop):
  - flushes FIFO ch;
  - clears tx_fifo_overflow[ch];
  - zeroes frame_i2c_o[ch] and relay_event_o[ch] next cycle;
  - suppresses relay_event_vld_o[ch].
- Inactive channels (ch >= NUM_OF_SMBUS_DEV): frame_i2c_o[ch] = 0 and relay_event_vld_o[ch] = 0 constantly; they have no FIFO storage.
- Reset assertion mid-frame immediately returns all state to reset values; no partial event is emitted afterwards.

Test Plan:
- Link up; push codes 3, 5, 7 on ch0 on consecutive cycles; issue 3 frame_tx_req strobes → frame_i2c_o[0] reads 3, then 5, then 7; the 4th request reads 0.
- DEPTH=4; push 5 events on ch2 with no request → tx_fifo_overflow[2]=1, and the frames carry the first 4 events. Then soft_i2c_channel_rst[2] → flag is 0 and the next frame reads 0.
- Full FIFO plus same-cycle push and frame_tx_req → no overflow; occupancy stays 4; the pushed code is emitted 4 frames later.
- frame_rx_vld with crc_ok=1, frame_i2c_i = {0,0,0,9,0,4} → next cycle relay_event_vld_o = 6'b000101, relay_event_o[0]=4, relay_event_o[2]=9; strobe lasts exactly 1 cycle.
- 3 frames with crc_ok=0 → no relay strobes; rx_drop_cnt=3. Preload the counter to FFFF, send one more bad frame → counter stays FFFF.
- link_operational dropped while ch1 holds 2 events → next cycle frame_i2c_o all 0, FIFO empty; after link returns, the first frame_tx_req reads 0 on ch1.
